wb_multi_port_bridge: RTL
=========================

Name: wb_multi_port_bridge

Overview:
- Bridges N native core memory channels onto one Wishbone classic master port toward the Controller.
- Native channel signals: en / we / addr / data / strobe out of the core; valid / data back into the core.
- Replaces hand-wired per-port glue in processor tops.
- Adds round-robin arbitration, per-channel write masking (read-only code ports), a bus timeout with error response, and a registered single-outstanding transaction.

Parameters:
- NUM_CH, 2, number of native channels (1..8); channel 0 = code port by convention.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- WRITE_MASK, 2'b10, bit i=1 allows writes on channel i; bit i=0 forces we=0 and data=0 on the bus.
- TIMEOUT_CYCLES, 1024, bus cycles without ack/err before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- ch_en_i  in  NUM_CH  per-channel request; held high with stable fields until ch_valid_o.
- ch_we_i  in  NUM_CH  per-channel write enable.
- ch_addr_i  in  NUM_CH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W].
- ch_data_i  in  NUM_CH*DATA_W  packed write data.
- ch_strobe_i  in  NUM_CH*(DATA_W/8)  packed byte enables.
- ch_valid_o  out  NUM_CH  one-cycle completion pulse per channel.
- ch_err_o  out  NUM_CH  error qualifier, valid with ch_valid_o.
- ch_data_o  out  DATA_W  shared read data, valid when any ch_valid_o is high.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe; always equal to wb_cyc_o.
- wb_we_o  out  1  Wishbone write enable.
- wb_addr_o  out  ADDR_W  Wishbone address.
- wb_data_o  out  DATA_W  Wishbone write data.
- wb_sel_o  out  DATA_W/8  Wishbone byte select.
- wb_data_i  in  DATA_W  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.

Behaviour:
- Reset (sync, active-high):
  - All outputs 0; state=IDLE.
  - Round-robin pointer=NUM_CH-1, so channel 0 is searched first.
  - Timeout counter=0.
  - Asserted mid-transaction: wb_cyc_o/wb_stb_o low on the following cycle; no ch_valid_o is issued for the aborted request.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - If any ch_en_i is high, grant the first set channel searching from ptr+1 mod NUM_CH upward with wrap.
  - On grant, register addr, we, data and sel into the wb_* outputs, set ptr=granted index, go to BUS; wb_cyc_o=wb_stb_o=1 from the next cycle.
  - If no ch_en_i is high, stay in IDLE.
- Field rules on grant:
  - Writes: wb_we_o = ch_we_i[g] & WRITE_MASK[g]; when the mask bit is 0, wb_data_o=0.
  - Reads (wb_we_o=0): wb_sel_o = all ones.
  - Writes: wb_sel_o = ch_strobe_i slice, passed unmodified (all-zero strobe is still issued).
  - Address passes through unmodified.
- BUS:
  - wb_* outputs hold stable.
  - On wb_ack_i or wb_err_i sampled high: drop cyc/stb next cycle; latch wb_data_i into ch_data_o (0 on err); latch err = wb_err_i; go to RESP.
  - If ack and err are both high, err wins.
  - Otherwise, if TIMEOUT_CYCLES≠0, increment the counter; when it reaches TIMEOUT_CYCLES-1 with no ack: drop cyc/stb, set err=1, ch_data_o=0, go to RESP.
  - Counter clears on entry to BUS.
- RESP:
  - ch_valid_o[g]=1 and ch_err_o[g]=err for exactly one cycle; all other bits 0; then go to IDLE.
  - ch_data_o holds its value until the next RESP.
- Latency: ch_en_i sampled at edge 0 → cyc high after edge 0 → ack sampled at edge k (k≥1) → ch_valid_o high after edge k+1. Minimum 2 cycles from request to valid.
- Request withdrawal:
  - An ungranted channel may drop ch_en_i with no effect.
  - After grant, fields are captured; later changes to ch_en_i or any field are ignored until valid.
- Outstanding transactions: at most one outstanding bus transaction; no pipelining.
- Fairness: after serving channel i, channel i has the lowest priority in the next arbitration. A channel holding en high continuously is re-served only after all other pending channels.
- Late acks: wb_ack_i or wb_err_i arriving in IDLE or RESP is ignored.

Test Plan:
- Single read, NUM_CH=2: ch0 en, addr=0x0000_0100; slave acks 1 cycle later with 0xDEADBEEF → wb_sel_o=4'hF, wb_we_o=0; ch_valid_o=2'b01 for one cycle with ch_data_o=0xDEADBEEF; total 3 cycles.
- Masked write: ch0 we=1, data=0x1234_5678 (WRITE_MASK bit0=0) → wb_we_o=0, wb_data_o=0. Same request on ch1 → wb_we_o=1, wb_data_o=0x1234_5678, wb_sel_o=strobe=4'b0011.
- Contention: ch0 and ch1 en held high continuously, slave acks immediately → grant order 0,1,0,1; ch_valid_o alternates 01,10; no channel is starved.
- Timeout: TIMEOUT_CYCLES=8, slave never acks → cyc high for exactly 8 cycles, then ch_valid_o with ch_err_o=1 and ch_data_o=0; bridge accepts the next request normally.
- Bus error: slave asserts wb_ack_i and wb_err_i in the same cycle → ch_err_o=1, ch_data_o=0.
- Reset mid-BUS: rst pulsed while cyc=1 → cyc=0 next cycle, no ch_valid_o; the next simultaneous ch0/ch1 request grants ch0 first.

Source files
------------

// File: rtl/wb_multi_port_bridge_if.sv
// Interfaces for wb_multi_port_bridge: the native per-core channel bundle and the
// Wishbone classic master bundle toward the Controller.

interface wb_multi_port_bridge_ch_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]            ch_en_i;
    logic [NUM_CH-1:0]            ch_we_i;
    logic [NUM_CH*ADDR_W-1:0]     ch_addr_i;
    logic [NUM_CH*DATA_W-1:0]     ch_data_i;
    logic [NUM_CH*(DATA_W/8)-1:0] ch_strobe_i;
    logic [NUM_CH-1:0]            ch_valid_o;
    logic [NUM_CH-1:0]            ch_err_o;
    logic [DATA_W-1:0]            ch_data_o;

    // master = the core side issuing requests, slave = the bridge serving them
    modport master (
        output ch_en_i, ch_we_i, ch_addr_i, ch_data_i, ch_strobe_i,
        input  ch_valid_o, ch_err_o, ch_data_o
    );

    modport slave (
        input  ch_en_i, ch_we_i, ch_addr_i, ch_data_i, ch_strobe_i,
        output ch_valid_o, ch_err_o, ch_data_o
    );
endinterface

interface wb_multi_port_bridge_wb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                wb_cyc_o;
    logic                wb_stb_o;
    logic                wb_we_o;
    logic [ADDR_W-1:0]   wb_addr_o;
    logic [DATA_W-1:0]   wb_data_o;
    logic [DATA_W/8-1:0] wb_sel_o;
    logic [DATA_W-1:0]   wb_data_i;
    logic                wb_ack_i;
    logic                wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o,
        input  wb_data_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o,
        output wb_data_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_multi_port_bridge.sv
// Round-robin bridge from N native core memory channels onto one Wishbone classic
// master, with per-channel write masking, bus timeout and one outstanding cycle.

module wb_multi_port_bridge #(
    parameter int                NUM_CH         = 2,
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [NUM_CH-1:0] WRITE_MASK     = 2'b10,
    parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
    input logic                        clk,
    input logic                        rst,
    wb_multi_port_bridge_ch_if.slave   ch,
    wb_multi_port_bridge_wb_if.master  wb
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [NUM_CH-1:0] valid_q, valid_d;
    logic [NUM_CH-1:0] verr_q, verr_d;

    logic              arb_found;
    logic [IDX_W-1:0]  arb_idx;
    logic [IDX_W-1:0]  cand;

    logic              g_we;
    logic              g_mask;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
    logic [SEL_W-1:0]  g_strobe;

    // Search starts just past the last served channel so it gets lowest priority.
    always_comb begin : arbiter
        arb_found = 1'b0;
        arb_idx   = ptr_q;
        cand      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_CH);
            if (!arb_found && ch.ch_en_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin : field_mux
        g_we     = 1'b0;
        g_mask   = 1'b0;
        g_addr   = '0;
        g_data   = '0;
        g_strobe = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                g_we     = ch.ch_we_i[i];
                g_mask   = WRITE_MASK[i];
                g_addr   = ch.ch_addr_i[i*ADDR_W +: ADDR_W];
                g_data   = ch.ch_data_i[i*DATA_W +: DATA_W];
                g_strobe = ch.ch_strobe_i[i*SEL_W +: SEL_W];
            end
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        valid_d = '0;
        verr_d  = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    ptr_d   = arb_idx;
                    cyc_d   = 1'b1;
                    we_d    = g_we & g_mask;
                    addr_d  = g_addr;
                    wdata_d = g_mask ? g_data : '0;
                    sel_d   = (g_we & g_mask) ? g_strobe : '1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end

            BUS: begin
                if (wb.wb_err_i) begin
                    cyc_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (wb.wb_ack_i) begin
                    cyc_d   = 1'b0;
                    rdata_d = wb.wb_data_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        cyc_d   = 1'b0;
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            RESP: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    valid_d[i] = (grant_q == IDX_W'(i));
                    verr_d[i]  = (grant_q == IDX_W'(i)) & err_q;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // Reset parks the pointer on the last channel so channel 0 wins the first search.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_CH - 1);
            grant_q <= '0;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            valid_q <= '0;
            verr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            verr_q  <= verr_d;
        end
    end

    assign wb.wb_cyc_o  = cyc_q;
    assign wb.wb_stb_o  = cyc_q;
    assign wb.wb_we_o   = we_q;
    assign wb.wb_addr_o = addr_q;
    assign wb.wb_data_o = wdata_q;
    assign wb.wb_sel_o  = sel_q;

    assign ch.ch_valid_o = valid_q;
    assign ch.ch_err_o   = verr_q;
    assign ch.ch_data_o  = rdata_q;

endmodule
